// File: rtl/gfx_pixel_coalescer128.sv
// Write-combining buffer: packs 8/16/32bpp pixel writes into one 16-byte line
// and evicts it as a single 128-bit bus write on full line, miss, flush or timeout.
module gfx_pixel_coalescer128 #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        color_depth_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  input  logic [ADDR_W-1:0] pix_addr_i,
  input  logic [31:0]       pix_color_i,
  input  logic              flush_i,
  output logic              idle_o,
  output logic              mem_cyc_o,
  output logic              mem_stb_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [15:0]       mem_sel_o,
  output logic [127:0]      mem_dat_o,
  input  logic              mem_ack_i
);

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  // 16bpp and 32bpp pixels are forced onto their natural alignment
  function automatic logic [3:0] lane_off(input logic [3:0] a, input logic [1:0] d);
    case (d)
      2'd1:    lane_off = {a[3:1], 1'b0};
      2'd3:    lane_off = {a[3:2], 2'b00};
      default: lane_off = a;
    endcase
  endfunction

  function automatic logic [15:0] pix_sel(input logic [3:0] a, input logic [1:0] d);
    logic [15:0] base;
    case (d)
      2'd1:    base = 16'h0003;
      2'd3:    base = 16'h000F;
      default: base = 16'h0001;
    endcase
    pix_sel = base << lane_off(a, d);
  endfunction

  function automatic logic [127:0] pix_data(input logic [3:0] a, input logic [31:0] c,
                                             input logic [1:0] d);
    logic [31:0] m;
    case (d)
      2'd1:    m = {16'h0000, c[15:0]};
      2'd3:    m = c;
      default: m = {24'h000000, c[7:0]};
    endcase
    pix_data = {96'd0, m} << {lane_off(a, d), 3'b000};
  endfunction

  function automatic logic [127:0] byte_mask(input logic [15:0] s);
    for (int i = 0; i < 16; i++) byte_mask[i*8 +: 8] = {8{s[i]}};
  endfunction

  logic [1:0]        r_state, w_state;
  logic [127:0]      r_data, w_data;
  logic [15:0]       r_sel, w_sel;
  logic [ADDR_W-5:0] r_tag, w_tag;
  logic              r_pend_vld, w_pend_vld;
  logic [ADDR_W-1:0] r_pend_addr, w_pend_addr;
  logic [31:0]       r_pend_color, w_pend_color;
  logic [1:0]        r_pend_depth, w_pend_depth;
  logic [TMO_W-1:0]  r_tmo, w_tmo;

  logic              w_accept, w_pix_ok, w_hit, w_wr;
  logic [15:0]       w_psel, w_msel;
  logic [127:0]      w_pdata;

  assign pix_ready_o = (r_state != S_WRITE) && !r_pend_vld;
  assign idle_o      = (r_state == S_EMPTY) && !r_pend_vld;
  assign w_accept    = pix_valid_i && pix_ready_o;
  assign w_pix_ok    = w_accept && (color_depth_i != 2'd2);
  assign w_hit       = (pix_addr_i[ADDR_W-1:4] == r_tag);
  assign w_psel      = pix_sel(pix_addr_i[3:0], color_depth_i);
  assign w_pdata     = pix_data(pix_addr_i[3:0], pix_color_i, color_depth_i);
  assign w_msel      = r_sel | w_psel;

  always_comb begin
    w_state      = r_state;
    w_data       = r_data;
    w_sel        = r_sel;
    w_tag        = r_tag;
    w_pend_vld   = r_pend_vld;
    w_pend_addr  = r_pend_addr;
    w_pend_color = r_pend_color;
    w_pend_depth = r_pend_depth;
    w_tmo        = '0;
    case (r_state)
      S_EMPTY: begin
        if (w_pix_ok) begin
          w_data  = w_pdata;
          w_sel   = w_psel;
          w_tag   = pix_addr_i[ADDR_W-1:4];
          w_state = S_COLLECT;
        end
      end
      S_COLLECT: begin
        w_tmo = r_tmo + 1'b1;
        if (w_pix_ok) begin
          w_tmo = '0;
          if (w_hit) begin
            w_data = (r_data & ~byte_mask(w_psel)) | w_pdata;
            w_sel  = w_msel;
            if (flush_i || (w_msel == 16'hFFFF)) w_state = S_WRITE;
          end else begin
            // Miss: park the pixel and evict the current line first
            w_pend_vld   = 1'b1;
            w_pend_addr  = pix_addr_i;
            w_pend_color = pix_color_i;
            w_pend_depth = color_depth_i;
            w_state      = S_WRITE;
          end
        end else if (flush_i) begin
          w_state = S_WRITE;
        end else if ((TIMEOUT != 0) && (w_tmo == TMO_W'(TIMEOUT))) begin
          w_state = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ack_i) begin
          w_data  = '0;
          w_sel   = '0;
          w_state = S_EMPTY;
          if (r_pend_vld) begin
            w_data     = pix_data(r_pend_addr[3:0], r_pend_color, r_pend_depth);
            w_sel      = pix_sel(r_pend_addr[3:0], r_pend_depth);
            w_tag      = r_pend_addr[ADDR_W-1:4];
            w_pend_vld = 1'b0;
            w_state    = S_COLLECT;
          end
        end
      end
      default: w_state = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_EMPTY;
      r_data       <= '0;
      r_sel        <= '0;
      r_tag        <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_color <= '0;
      r_pend_depth <= '0;
      r_tmo        <= '0;
    end else begin
      r_state      <= w_state;
      r_data       <= w_data;
      r_sel        <= w_sel;
      r_tag        <= w_tag;
      r_pend_vld   <= w_pend_vld;
      r_pend_addr  <= w_pend_addr;
      r_pend_color <= w_pend_color;
      r_pend_depth <= w_pend_depth;
      r_tmo        <= w_tmo;
    end
  end

  // Bus outputs decode straight from state so reset drops them without a clock
  assign w_wr      = (r_state == S_WRITE);
  assign mem_cyc_o = w_wr;
  assign mem_stb_o = w_wr;
  assign mem_we_o  = w_wr;
  assign mem_adr_o = w_wr ? {r_tag, 4'h0} : '0;
  assign mem_sel_o = w_wr ? r_sel : '0;
  assign mem_dat_o = w_wr ? (r_data & byte_mask(r_sel)) : '0;

endmodule

// File: tb/tb_gfx_pixel_coalescer128.sv
// Directed bench for gfx_pixel_coalescer128: packing, eviction triggers,
// timeout latency, reserved depth and asynchronous reset during a bus write.
module tb_gfx_pixel_coalescer128;
  logic         clk;
  logic         rst_ni;
  logic [1:0]   color_depth;
  logic         pix_valid;
  logic         pix_ready;
  logic [31:0]  pix_addr;
  logic [31:0]  pix_color;
  logic         flush;
  logic         idle;
  logic         mem_cyc, mem_stb, mem_we;
  logic [31:0]  mem_adr;
  logic [15:0]  mem_sel;
  logic [127:0] mem_dat;
  logic         mem_ack;

  int checks   = 0;
  int failures = 0;

  gfx_pixel_coalescer128 #(.ADDR_W(32), .TIMEOUT(15)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .color_depth_i(color_depth),
    .pix_valid_i(pix_valid), .pix_ready_o(pix_ready),
    .pix_addr_i(pix_addr), .pix_color_i(pix_color), .flush_i(flush),
    .idle_o(idle), .mem_cyc_o(mem_cyc), .mem_stb_o(mem_stb), .mem_we_o(mem_we),
    .mem_adr_o(mem_adr), .mem_sel_o(mem_sel), .mem_dat_o(mem_dat),
    .mem_ack_i(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_write();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; color_depth = 2'd0; pix_valid = 1'b0; pix_addr = '0;
    pix_color = '0; flush = 1'b0; mem_ack = 1'b0;
    #2;
    chk("rst_cyc", mem_cyc, 0);
    chk("rst_stb", mem_stb, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_adr", mem_adr, 0);
    chk("rst_sel", mem_sel, 0);
    chk("rst_dat", mem_dat, 0);
    chk("rst_ready", pix_ready, 1);
    chk("rst_idle", idle, 1);
    tick();
    rst_ni = 1'b1;
    tick();

    // Sixteen 8bpp pixels fill line 0x100
    color_depth = 2'd0;
    for (int i = 0; i < 16; i++) begin
      pix_valid = 1'b1;
      pix_addr  = 32'h100 + 32'(i);
      pix_color = 32'h10 + 32'(i);
      chk("fill_ready", pix_ready, 1);
      tick();
      if (i < 15) chk("fill_stb_low", mem_stb, 0);
    end
    pix_valid = 1'b0;
    chk("fill_stb", mem_stb, 1);
    chk("fill_cyc_we", {mem_cyc, mem_we}, 2'b11);
    chk("fill_adr", mem_adr, 32'h100);
    chk("fill_sel", mem_sel, 16'hFFFF);
    chk("fill_dat", mem_dat, 128'h1f1e1d1c1b1a19181716151413121110);
    chk("fill_ready_low", pix_ready, 0);
    tick();
    tick();
    chk("fill_hold_stb", mem_stb, 1);
    chk("fill_hold_dat", mem_dat, 128'h1f1e1d1c1b1a19181716151413121110);
    ack_write();
    chk("fill_ack_stb", mem_stb, 0);
    chk("fill_ack_ready", pix_ready, 1);
    chk("fill_ack_idle", idle, 1);
    tick();
    tick();
    chk("fill_single_write", mem_stb, 0);

    // 32bpp at 0x20 then a 16bpp miss at 0x40
    color_depth = 2'd3; pix_valid = 1'b1; pix_addr = 32'h20; pix_color = 32'hAABBCCDD;
    tick();
    color_depth = 2'd1; pix_addr = 32'h40; pix_color = 32'h00001234;
    tick();
    pix_valid = 1'b0;
    chk("miss_stb", mem_stb, 1);
    chk("miss_adr", mem_adr, 32'h20);
    chk("miss_sel", mem_sel, 16'h000F);
    chk("miss_dat", mem_dat, 128'hAABBCCDD);
    chk("miss_ready_low", pix_ready, 0);
    ack_write();
    chk("miss_ack_stb", mem_stb, 0);
    chk("miss_ack_ready", pix_ready, 1);
    chk("miss_ack_idle", idle, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pend_stb", mem_stb, 1);
    chk("pend_adr", mem_adr, 32'h40);
    chk("pend_sel", mem_sel, 16'h0003);
    chk("pend_dat", mem_dat, 128'h1234);
    ack_write();
    chk("pend_ack_idle", idle, 1);

    // 16bpp overwrite with alignment, then flush
    color_depth = 2'd1; pix_valid = 1'b1; pix_addr = 32'h32; pix_color = 32'h1111;
    tick();
    pix_addr = 32'h33; pix_color = 32'h2222;
    tick();
    pix_valid = 1'b0;
    chk("ovr_stb_low", mem_stb, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ovr_stb", mem_stb, 1);
    chk("ovr_adr", mem_adr, 32'h30);
    chk("ovr_sel", mem_sel, 16'h000C);
    chk("ovr_dat", mem_dat, 128'h22220000);
    ack_write();
    chk("ovr_ack_idle", idle, 1);

    // Timeout eviction of a lone 8bpp pixel
    color_depth = 2'd0; pix_valid = 1'b1; pix_addr = 32'h57; pix_color = 32'h5A;
    tick();
    pix_valid = 1'b0;
    for (int k = 1; k < 15; k++) tick();
    chk("tmo_stb_early", mem_stb, 0);
    tick();
    chk("tmo_stb", mem_stb, 1);
    chk("tmo_adr", mem_adr, 32'h50);
    chk("tmo_sel", mem_sel, 16'h0080);
    chk("tmo_dat", mem_dat, 128'h5A00000000000000);
    ack_write();
    chk("tmo_ack_idle", idle, 1);

    // Reserved depth is dropped; flush while empty is ignored
    color_depth = 2'd2; pix_valid = 1'b1; pix_addr = 32'h80; pix_color = 32'hFFFFFFFF;
    tick();
    chk("rsv_ready", pix_ready, 1);
    pix_addr = 32'h91;
    tick();
    pix_valid = 1'b0;
    chk("rsv_idle", idle, 1);
    chk("rsv_stb", mem_stb, 0);
    color_depth = 2'd0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("empty_flush_idle", idle, 1);
    chk("empty_flush_cyc", mem_cyc, 0);

    // Reset asserted while a write waits for ack
    pix_valid = 1'b1; pix_addr = 32'h200; pix_color = 32'h77;
    tick();
    pix_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("rstw_stb_before", mem_stb, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rstw_cyc", mem_cyc, 0);
    chk("rstw_stb", mem_stb, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    tick();
    chk("rstw_idle", idle, 1);
    chk("rstw_no_reissue", mem_stb, 0);
    chk("rstw_sel", mem_sel, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
